rep3_serial_tx: RTL and testbench
=================================

// Module: rep3_serial_tx
// PURPOSE
//   Serial transmitter for a triple-repetition line code. Accepts a parallel word via valid/ready,
//   frames it (start group, DATA_W data groups LSB first, stop group) and sends every symbol as
//   3 identical chips on one wire. Receive side recovers each symbol by 2-of-3 majority per chip group.
// PARAMETERS
//   DATA_W   8   payload bits per frame (>=1)
//   CLK_DIV  4   clk cycles per chip (>=1)
// PORTS
//   clk        in   1       rising-edge clock
//   rst        in   1       synchronous reset, active-high
//   din        in   DATA_W  payload word, sampled only on accept
//   din_valid  in   1       producer has a word
//   din_ready  out  1       block can accept; accept = din_valid & din_ready at a clk edge
//   tx_line    out  1       serial chip stream; idles high
//   tx_busy    out  1       frame in progress (START/DATA/STOP)
//   done       out  1       1-cycle pulse: frame fully sent
// BEHAVIOUR
//   - Reset (sync, all regs): state=IDLE, tx_line=1, din_ready=1, tx_busy=0, done=0, counters=0.
//   - FSM IDLE -> START -> DATA -> STOP -> IDLE. din_ready=1 only in IDLE; din_valid elsewhere ignored.
//   - Accept edge: din latched into shift reg, state->START. tx_line=0 from the following cycle.
//   - Symbol = 3 chips x CLK_DIV cycles = 3*CLK_DIV cycles. START symbol=0; DATA symbol i = din[i],
//     i=0..DATA_W-1; STOP symbol=1. tx_line is registered; constant across a whole symbol.
//   - Counters: div_cnt 0..CLK_DIV-1, chip_cnt 0..2, bit_cnt 0..DATA_W-1; each wraps to 0 and
//     advances the next one. Shift reg shifts right at end of each DATA symbol.
//   - Frame length F = (DATA_W+2)*3*CLK_DIV cycles of tx_busy=1, starting cycle after accept.
//   - Cycle after last STOP cycle: state=IDLE, tx_line=1, done=1, din_ready=1, tx_busy=0.
//     If din_valid=1 in that cycle, new word accepted there -> next START begins the following
//     cycle (one idle-high cycle between back-to-back frames; no other gap).
//   - done never asserted outside that single cycle; never asserted for an aborted frame.
//   - rst mid-frame: next cycle IDLE, tx_line=1, din_ready=1; latched word discarded, no done.
//   - rst has priority over accept in the same cycle.
//   - CLK_DIV=1: chips 1 cycle each; DATA_W=1: DATA state lasts exactly one symbol.
// TESTING
//   1. rst=1 2 cycles, din_valid=0 -> tx_line=1, din_ready=1, tx_busy=0, done=0; held while idle.
//   2. DATA_W=8, CLK_DIV=4, din=8'hA5 accepted at cycle 0 -> cycles 1-12 line=0; 13-24=1 (bit0);
//      25-36=0; ... 97-108=1 (bit7); 109-120=1 (stop); cycle 121 done=1, tx_busy=0.
//   3. din_valid held, 8'h00 then 8'hFF -> 2nd accept on done cycle of 1st frame, 2nd frame line=0
//      from next cycle; majority decode of each 3-chip group yields 8'h00 then 8'hFF.
//   4. Change din and pulse din_valid mid-frame -> no effect on tx_line, din_ready stays 0.
//   5. rst=1 during bit3 of a frame -> next cycle tx_line=1, din_ready=1, tx_busy=0; no done pulse.
//   6. DATA_W=1, CLK_DIV=1, din=1 -> line 0,0,0,1,1,1,1,1,1 then done on cycle 10 after accept.

Source files
------------

// File: rtl/rep3_serial_tx_if.sv
// rep3_serial_tx_if
//   Bundles the parallel-word handshake and the serial/status outputs of
//   the triple-repetition transmitter.
//   Signals:
//     din       payload word (producer -> transmitter)
//     din_valid producer has a word
//     din_ready transmitter can accept a word
//     tx_line   serial chip stream, idles high
//     tx_busy   frame in progress
//     done      one-cycle pulse when a frame has been fully sent
//   Modports:
//     master  producer / observer side
//     slave   transmitter side
interface rep3_serial_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic              din_ready;
  logic              tx_line;
  logic              tx_busy;
  logic              done;

  modport master (
    output din, din_valid,
    input  din_ready, tx_line, tx_busy, done
  );

  modport slave (
    input  din, din_valid,
    output din_ready, tx_line, tx_busy, done
  );
endinterface

// File: rtl/rep3_serial_tx.sv
// rep3_serial_tx
//   Serial transmitter for a triple-repetition line code. A word accepted
//   over valid/ready is framed as a start symbol (0), DATA_W data symbols
//   (LSB first) and a stop symbol (1). Every symbol is sent as 3 identical
//   chips of CLK_DIV clock cycles each, so a receiver can recover it by a
//   2-of-3 majority vote.
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous reset, active-high
//     bus  rep3_serial_tx_if.slave: din/din_valid in, din_ready/tx_line/
//          tx_busy/done out
//   Parameters:
//     DATA_W   payload bits per frame (>=1)
//     CLK_DIV  clock cycles per chip (>=1)
module rep3_serial_tx #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  rep3_serial_tx_if.slave  bus
);

  // Counter widths must stay >= 1 even when a parameter is 1.
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = (DATA_W  > 1) ? $clog2(DATA_W)  : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t            state_reg,   state_next;
  logic [DIV_W-1:0]  div_cnt_reg,  div_cnt_next;
  logic [1:0]        chip_cnt_reg, chip_cnt_next;
  logic [BIT_W-1:0]  bit_cnt_reg,  bit_cnt_next;
  logic [DATA_W-1:0] data_sr_reg,  data_sr_next;
  logic              tx_line_reg,  tx_line_next;
  logic              done_reg,     done_next;

  logic              div_wrap;
  logic              sym_end;
  logic [DATA_W-1:0] data_sr_shifted;

  assign div_wrap        = (div_cnt_reg == DIV_LAST);
  assign sym_end         = div_wrap && (chip_cnt_reg == 2'd2);
  assign data_sr_shifted = data_sr_reg >> 1;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      div_cnt_reg  <= '0;
      chip_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      data_sr_reg  <= '0;
      tx_line_reg  <= 1'b1;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      div_cnt_reg  <= div_cnt_next;
      chip_cnt_reg <= chip_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      data_sr_reg  <= data_sr_next;
      tx_line_reg  <= tx_line_next;
      done_reg     <= done_next;
    end
  end

  // Next-state and next-output logic. tx_line is registered, so the value
  // for the coming symbol is loaded on the last cycle of the current one.
  always_comb begin
    state_next    = state_reg;
    div_cnt_next  = div_cnt_reg;
    chip_cnt_next = chip_cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    data_sr_next  = data_sr_reg;
    tx_line_next  = tx_line_reg;
    done_next     = 1'b0;

    // Chip/symbol timing runs only while a frame is on the wire.
    if (state_reg != IDLE) begin
      if (div_wrap) begin
        div_cnt_next  = '0;
        chip_cnt_next = (chip_cnt_reg == 2'd2) ? 2'd0 : chip_cnt_reg + 2'd1;
      end else begin
        div_cnt_next  = div_cnt_reg + 1'b1;
      end
    end

    unique case (state_reg)
      IDLE: begin
        if (bus.din_valid) begin
          state_next    = START;
          data_sr_next  = bus.din;
          tx_line_next  = 1'b0;
          div_cnt_next  = '0;
          chip_cnt_next = '0;
          bit_cnt_next  = '0;
        end
      end
      START: begin
        if (sym_end) begin
          state_next   = DATA;
          tx_line_next = data_sr_reg[0];
        end
      end
      DATA: begin
        if (sym_end) begin
          data_sr_next = data_sr_shifted;
          if (bit_cnt_reg == BIT_LAST) begin
            state_next   = STOP;
            bit_cnt_next = '0;
            tx_line_next = 1'b1;
          end else begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
            // Next bit is what lands in bit 0 after this shift.
            tx_line_next = data_sr_shifted[0];
          end
        end
      end
      STOP: begin
        if (sym_end) begin
          state_next   = IDLE;
          tx_line_next = 1'b1;
          done_next    = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.din_ready = (state_reg == IDLE);
  assign bus.tx_busy   = (state_reg != IDLE);
  assign bus.tx_line   = tx_line_reg;
  assign bus.done      = done_reg;

endmodule

// File: tb/tb_rep3_serial_tx.sv
module tb_rep3_serial_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  rep3_serial_tx_if #(.DATA_W(8)) b0 ();
  rep3_serial_tx_if #(.DATA_W(1)) b1 ();

  rep3_serial_tx #(.DATA_W(8), .CLK_DIV(4)) u0 (
    .clk (clk),
    .rst (rst),
    .bus (b0)
  );

  rep3_serial_tx #(.DATA_W(1), .CLK_DIV(1)) u1 (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered in the accept cycle (din/din_valid already driven, u0 idle);
  // returns in the done cycle. mode 0: drop valid; mode 1: keep valid with
  // nxt so the next word is accepted on the done cycle; mode 2: wiggle
  // din/din_valid throughout the frame, then drop valid.
  task automatic run_frame(input logic [7:0] w, input int mode,
                           input logic [7:0] nxt, input string tag);
    logic [7:0] dec;
    int ones;
    int sym, chip, dv;
    logic exp_line;
    dec  = 8'h00;
    ones = 0;
    for (int c = 1; c <= 120; c++) begin
      step();
      sym  = (c - 1) / 12;
      chip = ((c - 1) % 12) / 4;
      dv   = (c - 1) % 4;
      if (sym == 0)      exp_line = 1'b0;
      else if (sym == 9) exp_line = 1'b1;
      else               exp_line = w[sym-1];
      check($sformatf("%s line c%0d", tag, c), {31'd0, b0.tx_line}, {31'd0, exp_line});
      if (dv == 0) begin
        check($sformatf("%s busy c%0d", tag, c),  {31'd0, b0.tx_busy},   32'd1);
        check($sformatf("%s ready c%0d", tag, c), {31'd0, b0.din_ready}, 32'd0);
        check($sformatf("%s done c%0d", tag, c),  {31'd0, b0.done},      32'd0);
      end
      // Majority decode: sample each chip mid-way, vote across 3 chips.
      if (chip == 0 && dv == 0) ones = 0;
      if (dv == 2) ones += int'(b0.tx_line);
      if (chip == 2 && dv == 3 && sym >= 1 && sym <= 8) dec[sym-1] = (ones >= 2);
      case (mode)
        1: begin
          b0.din_valid = 1'b1;
          b0.din       = nxt;
        end
        2: begin
          b0.din_valid = (c < 120) ? c[0] : 1'b0;
          b0.din       = 8'($urandom);
        end
        default: b0.din_valid = 1'b0;
      endcase
    end
    check($sformatf("%s decoded", tag), {24'd0, dec}, {24'd0, w});
    step();
    check($sformatf("%s done pulse", tag), {31'd0, b0.done},      32'd1);
    check($sformatf("%s done busy", tag),  {31'd0, b0.tx_busy},   32'd0);
    check($sformatf("%s done ready", tag), {31'd0, b0.din_ready}, 32'd1);
    check($sformatf("%s done line", tag),  {31'd0, b0.tx_line},   32'd1);
  endtask

  logic [8:0] t6_exp;

  initial begin
    b0.din = 8'h00; b0.din_valid = 1'b0;
    b1.din = 1'b0;  b1.din_valid = 1'b0;
    rst = 1'b1;

    // 1. Reset for 2 cycles, then held idle.
    step();
    step();
    check("rst line",  {31'd0, b0.tx_line},   32'd1);
    check("rst ready", {31'd0, b0.din_ready}, 32'd1);
    check("rst busy",  {31'd0, b0.tx_busy},   32'd0);
    check("rst done",  {31'd0, b0.done},      32'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("idle line %0d", i), {31'd0, b0.tx_line}, 32'd1);
      check($sformatf("idle busy %0d", i), {31'd0, b0.tx_busy}, 32'd0);
      check($sformatf("idle done %0d", i), {31'd0, b0.done},    32'd0);
    end
    $display("step 1 reset/idle checked");

    // 2. Single frame 8'hA5.
    b0.din = 8'hA5; b0.din_valid = 1'b1;
    run_frame(8'hA5, 0, 8'h00, "a5");
    step();
    check("a5 after done", {31'd0, b0.done}, 32'd0);
    $display("step 2 frame 8'hA5 sent");

    // 3. Back-to-back 8'h00 then 8'hFF with din_valid held.
    b0.din = 8'h00; b0.din_valid = 1'b1;
    run_frame(8'h00, 1, 8'hFF, "b2b0");
    run_frame(8'hFF, 0, 8'h00, "b2b1");
    step();
    check("b2b idle busy", {31'd0, b0.tx_busy}, 32'd0);
    $display("step 3 back-to-back 8'h00/8'hFF sent");

    // 4. Mid-frame din/din_valid activity is ignored.
    b0.din = 8'h3C; b0.din_valid = 1'b1;
    run_frame(8'h3C, 2, 8'h00, "ign");
    step();
    check("ign idle busy", {31'd0, b0.tx_busy}, 32'd0);
    $display("step 4 mid-frame input activity ignored");

    // 5. Reset during bit3 (symbol 4, cycles 49..60): abort, no done.
    b0.din = 8'h08; b0.din_valid = 1'b1;
    step();
    b0.din_valid = 1'b0;
    for (int i = 0; i < 49; i++) step();
    check("abort pre line", {31'd0, b0.tx_line}, 32'd1);
    check("abort pre busy", {31'd0, b0.tx_busy}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort line",  {31'd0, b0.tx_line},   32'd1);
    check("abort ready", {31'd0, b0.din_ready}, 32'd1);
    check("abort busy",  {31'd0, b0.tx_busy},   32'd0);
    check("abort done",  {31'd0, b0.done},      32'd0);
    for (int i = 0; i < 80; i++) begin
      step();
      check($sformatf("abort no done %0d", i), {30'd0, b0.done, b0.tx_busy}, 32'd0);
    end
    // Reset wins over an accept in the same cycle.
    b0.din = 8'hAA; b0.din_valid = 1'b1; rst = 1'b1;
    step();
    rst = 1'b0; b0.din_valid = 1'b0;
    check("rst prio busy", {31'd0, b0.tx_busy}, 32'd0);
    check("rst prio line", {31'd0, b0.tx_line}, 32'd1);
    step();
    check("rst prio busy2", {31'd0, b0.tx_busy}, 32'd0);
    $display("step 5 abort and reset priority checked");

    // 6. DATA_W=1, CLK_DIV=1, din=1.
    t6_exp = 9'b111111000;  // bit k = line in cycle k+1
    b1.din = 1'b1; b1.din_valid = 1'b1;
    step();
    b1.din_valid = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      check($sformatf("small line c%0d", c), {31'd0, b1.tx_line}, {31'd0, t6_exp[c-1]});
      check($sformatf("small done c%0d", c), {31'd0, b1.done},    32'd0);
      step();
    end
    check("small done pulse", {31'd0, b1.done},    32'd1);
    check("small done busy",  {31'd0, b1.tx_busy}, 32'd0);
    step();
    check("small done drop",  {31'd0, b1.done},    32'd0);
    $display("step 6 DATA_W=1 CLK_DIV=1 frame sent");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
